// File: rtl/chip8_timer_bank_if.sv
// CPU-side load/read port of the CHIP-8 timer bank.
// The CPU core drives the master side; the timer bank is the slave.
interface chip8_timer_bank_if #(
    parameter int NUM_TIMERS = 2
);
    localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [7:0]       wr_data;
    logic [SEL_W-1:0] rd_sel;
    logic [7:0]       rd_data;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        output rd_sel,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  rd_sel,
        output rd_data
    );
endinterface

// File: rtl/chip8_timer_bank.sv
// CHIP-8 tick generator plus a bank of 8-bit countdown timers (delay, sound, ...).
// Optional macro TIMER_BANK_PAUSE_EN adds a pause input that freezes both prescalers and all countdowns.
module chip8_timer_bank #(
    parameter int CLOCK_SPEED = 100000,
    parameter int CPU_SPEED   = 500,
    parameter int TIMER_HZ    = 60,
    parameter int NUM_TIMERS  = 2,
    parameter int SOUND_CH    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef TIMER_BANK_PAUSE_EN
    input  logic                  pause,
`endif
    chip8_timer_bank_if.slave     bus,
    output logic                  cpu_tick,
    output logic                  hz_tick,
    output logic [NUM_TIMERS-1:0] timer_active,
    output logic                  sound_on
);
    localparam int CPU_DIV = CLOCK_SPEED / CPU_SPEED;
    localparam int HZ_DIV  = CLOCK_SPEED / TIMER_HZ;
    localparam int CPU_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int HZ_W    = (HZ_DIV > 1) ? $clog2(HZ_DIV) : 1;
    localparam int SEL_W   = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

    localparam logic [CPU_W-1:0] CPU_LAST = CPU_W'(CPU_DIV - 1);
    localparam logic [HZ_W-1:0]  HZ_LAST  = HZ_W'(HZ_DIV - 1);

    logic [CPU_W-1:0] cpu_cnt;
    logic [HZ_W-1:0]  hz_cnt;
    logic [7:0]       timers [NUM_TIMERS];
    logic [7:0]       rd_mux;
    logic             run;

    // Pausing holds the prescaler phase rather than resetting it, so no tick is lost or repeated.
`ifdef TIMER_BANK_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // A tick is the cycle in which its prescaler sits at zero, so it is high straight out of reset.
    assign cpu_tick = run && (cpu_cnt == '0);
    assign hz_tick  = run && (hz_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt <= '0;
            hz_cnt  <= '0;
        end else if (run) begin
            cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + CPU_W'(1);
            hz_cnt  <= (hz_cnt == HZ_LAST) ? '0 : hz_cnt + HZ_W'(1);
        end
    end

    // A load beats a coincident decrement; out-of-range wr_sel matches no timer and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                timers[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (bus.wr_en && (bus.wr_sel == SEL_W'(i))) begin
                    timers[i] <= bus.wr_data;
                end else if (hz_tick && (timers[i] != 8'd0)) begin
                    timers[i] <= timers[i] - 8'd1;
                end
            end
        end
    end

    always_comb begin
        rd_mux = 8'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_mux = timers[i];
            end
        end
    end

    assign bus.rd_data = rd_mux;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_active
        assign timer_active[g] = |timers[g];
    end

    assign sound_on = timer_active[SOUND_CH];

endmodule

// File: doc/chip8_timer_bank.md
Name: chip8_timer_bank

Overview:
- Parametrised successor to the fixed two-output tick timer.
- Derives the CPU-step tick and the 60 Hz tick from the system clock.
- Adds a bank of NUM_TIMERS 8-bit CHIP-8 countdown registers (delay timer, sound timer, ...), decremented on the 60 Hz tick.
- Provides a CPU load/read port and the buzzer enable; sits between the clock source, the CPU core and the audio output.

Parameters:
- CLOCK_SPEED, 100000, system clock frequency in Hz.
- CPU_SPEED, 500, CPU tick rate in Hz; CPU divider = CLOCK_SPEED / CPU_SPEED (integer, truncated, must be >= 1).
- TIMER_HZ, 60, countdown tick rate in Hz; timer divider = CLOCK_SPEED / TIMER_HZ (truncated, >= 1; 100000/60 = 1666).
- NUM_TIMERS, 2, number of 8-bit countdown registers (>= 1); index 0 = delay timer.
- SOUND_CH, 1, index of the timer that drives sound_on (< NUM_TIMERS).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_tick  output  1  one-cycle pulse at CPU_SPEED.
- hz_tick  output  1  one-cycle pulse at TIMER_HZ.
- wr_en  input  1  load strobe for timer wr_sel.
- wr_sel  input  max(1,$clog2(NUM_TIMERS))  timer index to load.
- wr_data  input  8  load value.
- rd_sel  input  max(1,$clog2(NUM_TIMERS))  timer index to read.
- rd_data  output  8  current value of timer rd_sel (combinational).
- timer_active  output  NUM_TIMERS  bit i = timer i nonzero.
- sound_on  output  1  equals timer_active[SOUND_CH].

Behaviour:
- Reset (async, rst_n low): both prescaler counts = 0; all timers = 0.
  - During and right after reset: cpu_tick = 1, hz_tick = 1, rd_data = 0, timer_active = 0, sound_on = 0.
- Prescalers:
  - Each prescaler counts 0..DIV-1 and wraps to 0.
  - The tick is high exactly while its count == 0, i.e. high in the first cycle after reset and every DIV cycles thereafter: cycle index i ticks iff i % DIV == 0.
  - DIV = 1: tick constantly high.
  - Width = $clog2(DIV), minimum 1.
- Countdown, per timer i, on a clock edge with hz_tick high:
  - If value != 0: value - 1.
  - If value == 0: stays 0, no wrap to 255.
- Load:
  - wr_en high at an edge sets timer[wr_sel] = wr_data.
  - Visible on rd_data / timer_active the next cycle.
  - wr_sel >= NUM_TIMERS: write ignored.
- Simultaneous load and hz_tick on the same timer: load wins; the loaded value is not decremented on that edge.
  - Other timers decrement normally on that edge.
- Loading 0 stops a running timer immediately (next cycle): active bit clears, sound_on drops.
- Read:
  - rd_data = timer[rd_sel], combinational from registers, no read side effects.
  - rd_sel >= NUM_TIMERS returns 0.
- timer_active and sound_on are combinational from the registered values (OR-reduce per timer); no extra latency.
- Reset mid-countdown: all timers clear immediately (async); prescaler phases restart from 0.
- No clock-domain crossing; all inputs synchronous to clk.

Optional Feature:
- Macro: TIMER_BANK_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause is high, both prescaler counts hold, cpu_tick and hz_tick are forced low, and no timer decrements.
  - Loads via wr_en still take effect.
  - On pause release, counts resume from the held value; phase is preserved and no tick is skipped or duplicated.
- Not defined: no pause port; prescalers and countdown always free-run.

Test Plan:
- Reset release, default params, free-run 4*CLOCK_SPEED cycles -> cpu_tick high iff i%200==0; hz_tick high iff i%1666==0; both high at i=0.
- Write timer0=3 at cycle 10 -> rd_data (rd_sel=0) reads 3 from cycle 11, then 2, 1, 0 after successive hz_ticks (cycles 1666, 3332, 4998); stays 0 after the next tick, no wrap; timer_active[0] falls after cycle 4998.
- Write timer1=5 -> sound_on high next cycle, low after the 5th hz_tick. Write timer1=0 while running -> sound_on low next cycle.
- Write timer0=7 on the exact edge where hz_tick=1, with timer1=4 already loaded -> timer0 reads 7 (not 6), timer1 reads 3.
- Assert rst_n low mid-count with timers 9 and 4 -> all outputs back to reset values without a clock edge; ticks restart with i=0 phase after release.
- With TIMER_BANK_PAUSE_EN: pause for 500 cycles starting at cycle 100 -> next cpu_tick at cycle 700, next hz_tick at cycle 2166, timers frozen; a write during pause is applied.
